answer_grader: RTL

ANSWER_GRADER -- requirements
Module: answer_grader

---
 rtl/answer_grader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/answer_grader.sv
// answer_grader: grades five user-entered characters against characters latched at start.
// Build macro GRADER_RETRY_EN gives each character one retry after a wrong answer.
module answer_grader (
    input  logic       clk,
    input  logic       rst,
    input  logic       allowgt,
    input  logic [3:0] exp1,
    input  logic [3:0] exp2,
    input  logic [3:0] exp3,
    input  logic [3:0] exp4,
    input  logic [3:0] exp5,
    input  logic [3:0] ansin,
    input  logic       submit,
    input  logic       timeout,
    output logic       reqtimer,
    output logic [2:0] ansidx,
    output logic       correct,
    output logic       wrong,
    output logic [2:0] score,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_CHECK,
        S_NEXT,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [4:0][3:0] exp_q;
    logic [3:0]      ans_q;
    logic            submit_q;
    logic            edge_q;
    logic            reqtimer_q;
    logic            correct_q;
    logic            wrong_q;
    logic            busy_q;
    logic            done_q;
    logic [2:0]      ansidx_q;
    logic [2:0]      score_q;
`ifdef GRADER_RETRY_EN
    logic            retry_q;
`endif

    logic sub_rise;
    logic match;

    assign sub_rise = submit & ~submit_q;
    assign match    = (ans_q == exp_q[ansidx_q]);

    // A raw submit rise in the same cycle as timeout masks the timeout; the
    // registered edge then moves WAIT to CHECK on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            exp_q      <= '0;
            ans_q      <= '0;
            submit_q   <= 1'b0;
            edge_q     <= 1'b0;
            reqtimer_q <= 1'b0;
            correct_q  <= 1'b0;
            wrong_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ansidx_q   <= '0;
            score_q    <= '0;
`ifdef GRADER_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            submit_q  <= submit;
            edge_q    <= sub_rise;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (allowgt) begin
                        exp_q    <= {exp5, exp4, exp3, exp2, exp1};
                        ansidx_q <= '0;
                        score_q  <= '0;
                        done_q   <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef GRADER_RETRY_EN
                        retry_q  <= 1'b0;
`endif
                        state_q  <= S_ARM;
                    end
                end
                S_ARM: begin
                    reqtimer_q <= 1'b1;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (edge_q) begin
                        ans_q      <= ansin;
                        reqtimer_q <= 1'b0;
                        state_q    <= S_CHECK;
                    end else if (timeout && !sub_rise) begin
                        reqtimer_q <= 1'b0;
                        wrong_q    <= 1'b1;
                        state_q    <= S_NEXT;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        correct_q <= 1'b1;
                        if (score_q != 3'd5) begin
                            score_q <= score_q + 3'd1;
                        end
                        state_q   <= S_NEXT;
                    end else begin
                        wrong_q <= 1'b1;
`ifdef GRADER_RETRY_EN
                        if (!retry_q) begin
                            retry_q <= 1'b1;
                            state_q <= S_ARM;
                        end else begin
                            state_q <= S_NEXT;
                        end
`else
                        state_q <= S_NEXT;
`endif
                    end
                end
                S_NEXT: begin
                    if (ansidx_q == 3'd4) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        ansidx_q <= ansidx_q + 3'd1;
`ifdef GRADER_RETRY_EN
                        retry_q  <= 1'b0;
`endif
                        state_q  <= S_ARM;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign reqtimer = reqtimer_q;
    assign ansidx   = ansidx_q;
    assign correct  = correct_q;
    assign wrong    = wrong_q;
    assign score    = score_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
